// File: rtl/ccff_ctrl_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_ctrl_pkg;

  localparam int unsigned DEF_WORD_W    = 8;
  localparam int unsigned DEF_CHAIN_LEN = 36;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ccff_state_e;

  // Number of bitstream words needed to cover a chain of chain_len bits.
  function automatic int unsigned words_for(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Collects bits leaving ccff_tail into readback words and holds them on a
// valid/ready output; flags when a word cannot complete because the output is full.
module ccff_rb_packer
  import ccff_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned WBIT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              word_last,
  input  logic [WBIT_W-1:0] wbit,
  input  logic              tail_bit,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              word_full_blocked,
  output logic              rb_drained_c
);

  logic [WORD_W-1:0] rx_sreg_q, rx_sreg_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0] word_cap;

  // A completing word may not overwrite a held word the consumer has not taken.
  assign word_full_blocked = word_last & rb_valid_q & ~rb_ready;
  // Output register will be empty after this edge.
  assign rb_drained_c      = ~rb_valid_q | rb_ready;
  assign rb_data           = rb_data_q;
  assign rb_valid          = rb_valid_q;

  // Capture the tail bit; on the last bit publish the word and restart collection.
  always_comb begin
    rx_sreg_d      = rx_sreg_q;
    rb_data_d      = rb_data_q;
    rb_valid_d     = rb_valid_q;
    word_cap       = rx_sreg_q;
    word_cap[wbit] = tail_bit;
    if (rb_valid_q && rb_ready) begin
      rb_valid_d = 1'b0;
    end
    if (shift_en) begin
      if (word_last) begin
        rb_data_d  = word_cap;
        rb_valid_d = 1'b1;
        rx_sreg_d  = '0;
      end else begin
        rx_sreg_d  = word_cap;
      end
    end
  end

  // Readback state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sreg_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rx_sreg_q  <= rx_sreg_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first into a configuration chain while
// returning the displaced chain contents as readback words.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en
);

  localparam int unsigned WBIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned BCNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  ccff_state_e       state_q, state_d;
  logic [WORD_W-1:0] tx_sreg_q, tx_sreg_d;
  logic [WBIT_W-1:0] wbit_q, wbit_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              word_end_c;
  logic              chain_end_c;
  logic              word_last_c;
  logic              word_full_blocked;
  logic              rb_drained_c;

  assign word_end_c  = (wbit_q == WBIT_W'(WORD_W - 1));
  assign chain_end_c = (bcnt_q == BCNT_W'(CHAIN_LEN - 1));
  // The current SHIFT cycle would finish a readback word.
  assign word_last_c = (state_q == ST_SHIFT) & (word_end_c | chain_end_c);

  assign busy = busy_q;
  assign done = done_q;

  // Readback collection and output handshake.
  ccff_rb_packer #(
    .WORD_W (WORD_W),
    .WBIT_W (WBIT_W)
  ) u_rb_packer (
    .clk               (prog_clk),
    .rst_n             (prog_reset_n),
    .shift_en          (ccff_shift_en),
    .word_last         (word_last_c),
    .wbit              (wbit_q),
    .tail_bit          (ccff_tail),
    .rb_ready          (rb_ready),
    .rb_data           (rb_data),
    .rb_valid          (rb_valid),
    .word_full_blocked (word_full_blocked),
    .rb_drained_c      (rb_drained_c)
  );

  // Next-state, datapath update and combinational chain/handshake controls.
  always_comb begin
    state_d       = state_q;
    tx_sreg_d     = tx_sreg_q;
    wbit_d        = wbit_q;
    bcnt_d        = bcnt_q;
    cfg_ready     = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          tx_sreg_d = cfg_data;
          wbit_d    = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ccff_head     = tx_sreg_q[0];
        ccff_shift_en = ~word_full_blocked;
        if (ccff_shift_en) begin
          tx_sreg_d = tx_sreg_q >> 1;
          wbit_d    = wbit_q + WBIT_W'(1);
          bcnt_d    = bcnt_q + BCNT_W'(1);
          if (chain_end_c) begin
            state_d = ST_DRAIN;
          end else if (word_end_c) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (rb_drained_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        wbit_d  = '0;
        bcnt_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered status flops.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q   <= ST_IDLE;
      tx_sreg_q <= '0;
      wbit_q    <= '0;
      bcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sreg_q <= tx_sreg_d;
      wbit_q    <= wbit_d;
      bcnt_q    <= bcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader driving a 36-bit chain model.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CHAIN_LEN = 36;

  logic        prog_clk     = 1'b0;
  logic        prog_reset_n = 1'b0;
  logic        start        = 1'b0;
  logic        cfg_valid    = 1'b0;
  logic        rb_ready     = 1'b1;
  logic [7:0]  cfg_data     = 8'h00;
  logic        busy, done, cfg_ready, rb_valid, ccff_head, ccff_shift_en, ccff_tail;
  logic [7:0]  rb_data;

  logic [35:0] chain = 36'hA5A5A5A5F;
  logic [7:0]  sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int shift_total = 0;
  int stall_total = 0;
  int last_stall_shift = -1;
  int pass_base = 0;

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain[0];

  ccff_chain_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .rb_ready      (rb_ready),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .ccff_shift_en (ccff_shift_en)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Chain model: advances only on enabled edges, tail seen before the shift.
  initial forever begin
    @(posedge prog_clk);
    cyc <= cyc + 1;
    if (ccff_shift_en) begin
      chain       <= {ccff_head, chain[35:1]};
      shift_total <= shift_total + 1;
    end
  end

  // Readback monitor: pops the expected word on every accepted readback.
  initial begin : rb_mon
    logic [7:0] e;
    forever begin
      @(posedge prog_clk);
      if (prog_reset_n && rb_valid && rb_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rb_unexpected: got 0x%0h expected no word", rb_data);
        end else begin
          e = sb_q.pop_front();
          check("rb_data", 64'(rb_data), 64'(e));
        end
      end
    end
  end

  // Mid-cycle monitor: no shifting outside a pass, and stall bookkeeping.
  initial forever begin
    @(negedge prog_clk);
    #1;
    check("shift_en_when_idle", 64'(ccff_shift_en & ~busy), 64'(0));
    if (busy && !cfg_ready && !ccff_shift_en && (shift_total - pass_base) < int'(CHAIN_LEN)) begin
      stall_total++;
      last_stall_shift = shift_total - pass_base;
    end
  end

  task automatic send_word(input logic [7:0] w, input int gap);
    int guard = 0;
    while (!cfg_ready && guard < 100) begin
      @(negedge prog_clk);
      guard++;
    end
    check("cfg_ready_wait", 64'(cfg_ready), 64'(1));
    for (int g = 0; g < gap; g++) begin
      check("gap_shift_en", 64'(ccff_shift_en), 64'(0));
      @(negedge prog_clk);
    end
    cfg_data  = w;
    cfg_valid = 1'b1;
    @(negedge prog_clk);
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
  endtask

  task automatic run_pass(input logic [39:0] wv, input int gap, input bit bp, input bit spulse,
                          input bit use_snap, input logic [39:0] exp_rb, input int exp_lat,
                          input logic [35:0] exp_chain, input int exp_stalls, input int exp_pos);
    logic [35:0] snap;
    logic [7:0]  rw;
    int          s_cyc;
    int          guard;
    int          st0;
    snap = chain;
    for (int i = 0; i < 5; i++) begin
      if (use_snap) begin
        rw = 8'h00;
        for (int b = 0; b < 8; b++) begin
          if (i * 8 + b < 36) rw[b] = snap[i * 8 + b];
        end
      end else begin
        rw = exp_rb[i * 8 +: 8];
      end
      sb_q.push_back(rw);
    end
    pass_base = shift_total;
    st0       = stall_total;
    start     = 1'b1;
    s_cyc     = cyc;
    @(negedge prog_clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    fork
      begin
        for (int i = 0; i < 5; i++) send_word(wv[i * 8 +: 8], gap);
      end
      begin
        if (bp) begin
          guard = 0;
          while (!rb_valid && guard < 100) begin
            @(negedge prog_clk);
            guard++;
          end
          rb_ready = 1'b0;
          repeat (10) @(negedge prog_clk);
          rb_ready = 1'b1;
        end
      end
      begin
        if (spulse) begin
          repeat (12) @(negedge prog_clk);
          check("in_shift_at_pulse", 64'(ccff_shift_en), 64'(1));
          start = 1'b1;
          @(negedge prog_clk);
          start = 1'b0;
        end
      end
    join
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge prog_clk);
      guard++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("done_latency", 64'(cyc - s_cyc), 64'(exp_lat));
    @(negedge prog_clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
    check("chain_contents", 64'(chain), 64'(exp_chain));
    check("rb_all_returned", 64'(sb_q.size()), 64'(0));
    check("stall_cycles", 64'(stall_total - st0), 64'(exp_stalls));
    if (exp_stalls > 0) check("stall_position", 64'(last_stall_shift), 64'(exp_pos));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle
    repeat (3) @(negedge prog_clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
    check("rst_rb_valid", 64'(rb_valid), 64'(0));
    check("rst_rb_data", 64'(rb_data), 64'(0));
    check("rst_head", 64'(ccff_head), 64'(0));
    check("rst_shift_en", 64'(ccff_shift_en), 64'(0));
    prog_reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge prog_clk);
      check("idle_shift_en", 64'(ccff_shift_en), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_cfg_ready", 64'(cfg_ready), 64'(0));
    end
    check("idle_chain", 64'(chain), 64'(36'hA5A5A5A5F));

    // Full pass, no gaps
    run_pass(40'h0F44332211, 0, 1'b0, 1'b0, 1'b0, 40'h0A5A5A5A5F, 43, 36'hF44332211, 0, 0);
    // Gaps of 3 cycles before every word
    run_pass(40'h0F44332211, 3, 1'b0, 1'b0, 1'b0, 40'h0F44332211, 58, 36'hF44332211, 0, 0);
    // Readback backpressure after the first word
    run_pass(40'h05EFBEADDE, 0, 1'b1, 1'b0, 1'b0, 40'h0F44332211, 45, 36'h5EFBEADDE, 2, 15);
    // start pulsed while shifting
    run_pass(40'h0F44332211, 0, 1'b0, 1'b1, 1'b0, 40'h05EFBEADDE, 43, 36'hF44332211, 0, 0);

    // Reset in the middle of the third word
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    sb_q.push_back(8'h33);
    sb_q.push_back(8'h44);
    sb_q.push_back(8'h0F);
    pass_base = shift_total;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    send_word(8'hDE, 0);
    send_word(8'hAD, 0);
    send_word(8'hBE, 0);
    repeat (3) @(negedge prog_clk);
    check("mid_word3_shifting", 64'(ccff_shift_en), 64'(1));
    prog_reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_shift_en", 64'(ccff_shift_en), 64'(0));
    check("arst_rb_valid", 64'(rb_valid), 64'(0));
    check("arst_cfg_ready", 64'(cfg_ready), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("rb_words_before_reset", 64'(sb_q.size()), 64'(3));
    sb_q.delete();
    repeat (2) @(negedge prog_clk);
    prog_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      check("post_rst_done", 64'(done), 64'(0));
      check("post_rst_busy", 64'(busy), 64'(0));
    end

    // Fresh pass after the aborted one
    run_pass(40'h05EFBEADDE, 0, 1'b0, 1'b0, 1'b1, 40'h0, 43, 36'h5EFBEADDE, 0, 0);

    repeat (2) @(negedge prog_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
